// File: rtl/sv_modmul_pkg.sv
// Shared types for the sv_modmul modular arithmetic unit.
package sv_modmul_pkg;

  typedef enum logic [1:0] {
    MODE_MUL = 2'd0,
    MODE_ADD = 2'd1,
    MODE_SUB = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The reserved encoding 3 falls back to multiplication.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_ADD;
      2'd2:    return MODE_SUB;
      default: return MODE_MUL;
    endcase
  endfunction

endpackage

// File: rtl/sv_modmul_if.sv
// Operand/result handshake bundle between a requester and sv_modmul.
interface sv_modmul_if #(
  parameter int DATA_WIDTH = 512
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode_i;
  logic [DATA_WIDTH-1:0] q_i;
  logic [DATA_WIDTH-1:0] x_i;
  logic [DATA_WIDTH-1:0] y_i;
  logic                  abort_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] p_o;
  logic                  err_o;

  modport master (
    output in_valid, mode_i, q_i, x_i, y_i, abort_i, out_ready,
    input  in_ready, out_valid, p_o, err_o
  );

  modport slave (
    input  in_valid, mode_i, q_i, x_i, y_i, abort_i, out_ready,
    output in_ready, out_valid, p_o, err_o
  );
endinterface

// File: rtl/sv_modmul_step.sv
// Combinational block of BITS_PER_CYCLE interleaved-reduction rounds, x bits MSB first.
module sv_modmul_step #(
  parameter int DATA_WIDTH     = 512,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [DATA_WIDTH-1:0]     q,
  input  logic [DATA_WIDTH-1:0]     y,
  input  logic [DATA_WIDTH-1:0]     z,
  input  logic [BITS_PER_CYCLE-1:0] x_bits,
  output logic [DATA_WIDTH-1:0]     z_next
);
  localparam int AW = DATA_WIDTH + 2;

  logic [AW-1:0] acc_s;

  function automatic logic [AW-1:0] cond_sub(input logic [AW-1:0] a, input logic [AW-1:0] m);
    return (a >= m) ? (a - m) : a;
  endfunction

  // With z < q and y < q, 2z + y < 3q, so two conditional subtractions suffice.
  always_comb begin
    acc_s = {2'b00, z};
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      acc_s = {acc_s[AW-2:0], 1'b0} + (x_bits[i] ? {2'b00, y} : {AW{1'b0}});
      acc_s = cond_sub(acc_s, {2'b00, q});
      acc_s = cond_sub(acc_s, {2'b00, q});
    end
    z_next = acc_s[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/sv_modmul.sv
// Modular multiply/add/subtract unit: result = (x op y) mod q, with
// operand legality check and a valid/ready handshake on both sides.
module sv_modmul
  import sv_modmul_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int BITS_PER_CYCLE = 4
) (
  input logic        clk,
  input logic        areset,
  sv_modmul_if.slave bus
);
  localparam int            ROUNDS   = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int            CW       = $clog2(ROUNDS) + 1;
  localparam logic [CW-1:0] LAST_RND = CW'(ROUNDS - 1);

  state_e                state_r, state_next_s;
  mode_e                 mode_r;
  logic [CW-1:0]         cnt_r;
  logic [DATA_WIDTH-1:0] q_r, x_r, y_r, z_r, p_r;
  logic                  err_r, out_valid_r, in_ready_r;

  logic                  accept_s, illegal_s, last_calc_s;
  logic [DATA_WIDTH-1:0] z_next_s, add_res_s, sub_res_s, result_s;
  logic [DATA_WIDTH:0]   sum_s;

  assign illegal_s   = (bus.x_i >= bus.q_i) || (bus.y_i >= bus.q_i) || (bus.q_i == {DATA_WIDTH{1'b0}});
  assign accept_s    = (state_r == ST_IDLE) && bus.in_valid;
  assign last_calc_s = (mode_r != MODE_MUL) || (cnt_r == LAST_RND);

  // x is shifted left each MUL cycle, so the next bits are always on top.
  sv_modmul_step #(
    .DATA_WIDTH    (DATA_WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .q     (q_r),
    .y     (y_r),
    .z     (z_r),
    .x_bits(x_r[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
    .z_next(z_next_s)
  );

  assign sum_s     = {1'b0, x_r} + {1'b0, y_r};
  assign add_res_s = (sum_s >= {1'b0, q_r}) ? DATA_WIDTH'(sum_s - {1'b0, q_r}) : sum_s[DATA_WIDTH-1:0];
  assign sub_res_s = (x_r < y_r) ? (x_r - y_r + q_r) : (x_r - y_r);

  // Result selection by the registered mode.
  always_comb begin
    result_s = z_next_s;
    case (mode_r)
      MODE_ADD: result_s = add_res_s;
      MODE_SUB: result_s = sub_res_s;
      default:  result_s = z_next_s;
    endcase
  end

  // Next-state logic; abort wins over out_ready.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) state_next_s = illegal_s ? ST_DONE : ST_CALC;
        else              state_next_s = ST_IDLE;
      end
      ST_CALC: begin
        if (bus.abort_i)       state_next_s = ST_IDLE;
        else if (last_calc_s)  state_next_s = ST_DONE;
        else                   state_next_s = ST_CALC;
      end
      ST_DONE: begin
        if (bus.abort_i || bus.out_ready) state_next_s = ST_IDLE;
        else                              state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == ST_DONE);
      in_ready_r  <= (state_next_s == ST_IDLE);
    end
  end

  // Operand capture, reduction rounds and result loading.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      mode_r <= MODE_MUL;
      cnt_r  <= {CW{1'b0}};
      q_r    <= {DATA_WIDTH{1'b0}};
      x_r    <= {DATA_WIDTH{1'b0}};
      y_r    <= {DATA_WIDTH{1'b0}};
      z_r    <= {DATA_WIDTH{1'b0}};
      p_r    <= {DATA_WIDTH{1'b0}};
      err_r  <= 1'b0;
    end else if (accept_s) begin
      mode_r <= decode_mode(bus.mode_i);
      cnt_r  <= {CW{1'b0}};
      q_r    <= bus.q_i;
      x_r    <= bus.x_i;
      y_r    <= bus.y_i;
      z_r    <= {DATA_WIDTH{1'b0}};
      if (illegal_s) begin
        p_r   <= {DATA_WIDTH{1'b0}};
        err_r <= 1'b1;
      end
    end else if ((state_r == ST_CALC) && !bus.abort_i) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      if (mode_r == MODE_MUL) begin
        z_r <= z_next_s;
        x_r <= x_r << BITS_PER_CYCLE;
      end
      if (last_calc_s) begin
        p_r   <= result_s;
        err_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.p_o       = p_r;
  assign bus.err_o     = err_r;
endmodule

// File: tb/tb_sv_modmul.sv
// Directed-vector bench for sv_modmul at DATA_WIDTH=8, BITS_PER_CYCLE=2, q=251.
module tb_sv_modmul;
  logic clk;
  logic areset;
  int   n_cmp = 0;
  int   n_err = 0;

  sv_modmul_if #(.DATA_WIDTH(8)) bus ();

  sv_modmul #(
    .DATA_WIDTH    (8),
    .BITS_PER_CYCLE(2)
  ) dut (
    .clk   (clk),
    .areset(areset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One operation: drive, measure latency from the acceptance edge, optionally stall, then handshake.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [7:0] q,
                        input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp_p,
                        input logic exp_err, input int exp_lat, input int hold);
    int   lat;
    logic stable;
    @(negedge clk);
    check({tag, "_inrdy"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.mode_i   = m;
    bus.q_i      = q;
    bus.x_i      = x;
    bus.y_i      = y;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        bus.mode_i   = 2'd1;
        bus.q_i      = 8'h00;
        bus.x_i      = 8'hFF;
        bus.y_i      = 8'hFF;
      end
    end while (!bus.out_valid && lat < 40);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_p"}, bus.p_o, exp_p);
    check({tag, "_err"}, bus.err_o, exp_err);
    check({tag, "_busy"}, bus.in_ready, 0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.p_o !== exp_p || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check({tag, "_hold"}, stable, 1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovl_after"}, bus.out_valid, 0);
    check({tag, "_inrdy_after"}, bus.in_ready, 1);
  endtask

  initial begin
    logic seen;
    areset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mode_i    = 2'd0;
    bus.q_i       = 8'd0;
    bus.x_i       = 8'd0;
    bus.y_i       = 8'd0;
    bus.abort_i   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p", bus.p_o, 0);
    check("rst_err", bus.err_o, 0);
    check("rst_ovl", bus.out_valid, 0);
    @(negedge clk) areset = 1'b1;
    @(posedge clk); #1;
    check("rst_inrdy", bus.in_ready, 1);

    // 200*100 mod 251 = 171, with a 10-cycle consumer stall
    run_op("mul", 2'd0, 8'd251, 8'd200, 8'd100, 8'd171, 1'b0, 5, 10);

    // abort during the second CALC cycle
    @(negedge clk);
    bus.in_valid = 1'b1; bus.mode_i = 2'd0; bus.q_i = 8'd251; bus.x_i = 8'd200; bus.y_i = 8'd100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.abort_i = 1'b1;
    @(posedge clk); #1;
    bus.abort_i = 1'b0;
    check("abort_ovl", bus.out_valid, 0);
    check("abort_inrdy", bus.in_ready, 1);
    check("abort_p", bus.p_o, 171);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_ovl", seen, 0);
    run_op("mul_3x5", 2'd0, 8'd251, 8'd3, 8'd5, 8'd15, 1'b0, 5, 0);

    run_op("add_wrap", 2'd1, 8'd251, 8'd200, 8'd100, 8'd49, 1'b0, 2, 0);
    run_op("sub_wrap", 2'd2, 8'd251, 8'd100, 8'd200, 8'd151, 1'b0, 2, 0);
    run_op("add_plain", 2'd1, 8'd251, 8'd10, 8'd20, 8'd30, 1'b0, 2, 0);
    run_op("sub_plain", 2'd2, 8'd251, 8'd200, 8'd100, 8'd100, 1'b0, 2, 0);

    // reset pulsed mid-CALC
    @(negedge clk);
    bus.in_valid = 1'b1; bus.mode_i = 2'd0; bus.q_i = 8'd251; bus.x_i = 8'd7; bus.y_i = 8'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    areset = 1'b0;
    #1;
    check("mrst_p", bus.p_o, 0);
    check("mrst_err", bus.err_o, 0);
    check("mrst_ovl", bus.out_valid, 0);
    @(negedge clk) areset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("mrst_inrdy", bus.in_ready, 1);
    check("mrst_no_ovl", seen, 0);

    run_op("mul_rsvd", 2'd3, 8'd251, 8'd3, 8'd5, 8'd15, 1'b0, 5, 0);
    run_op("mul_full", 2'd0, 8'd251, 8'd250, 8'd250, 8'd1, 1'b0, 5, 0);
    run_op("err_x", 2'd0, 8'd251, 8'd251, 8'd5, 8'd0, 1'b1, 1, 0);
    run_op("err_y", 2'd1, 8'd251, 8'd5, 8'd251, 8'd0, 1'b1, 1, 0);
    run_op("err_q0", 2'd2, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sv_modmul.md
SV_MODMUL -- requirements
Module: sv_modmul

Interface
REQ-001 Parameter DATA_WIDTH, default 512: operand/modulus width in bits; SHALL be a multiple of BITS_PER_CYCLE.
REQ-002 Parameter BITS_PER_CYCLE, default 4: multiplier bits consumed per clock in MUL mode; legal values 1, 2, 4, 8.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 areset  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set and mode valid.
REQ-006 in_ready  output  1  block accepts operands; high only in IDLE.
REQ-007 mode_i  input  2  operation: 0 MUL, 1 ADD, 2 SUB, 3 reserved (treated as MUL).
REQ-008 q_i, x_i, y_i  input  DATA_WIDTH each  modulus, first operand, second operand; flat little-endian vectors.
REQ-009 abort_i  input  1  discard the current operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 p_o  output  DATA_WIDTH  result (x*y, x+y or x-y) mod q.
REQ-013 err_o  output  1  qualifies p_o: x >= q, y >= q or q == 0.

Function
REQ-014 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-015 IDLE: a transfer occurs when in_valid and in_ready are both high; q, x, y and mode SHALL be registered; inputs SHALL be ignored after acceptance.
REQ-016 On acceptance with an illegal operand (REQ-013), the block SHALL go directly to DONE with err_o=1 and p_o=0.
REQ-017 MUL: MSB-first interleaved reduction; per bit z <= (2z + x[bit]*y) mod q, using a DATA_WIDTH+2-bit intermediate and at most two conditional subtractions of q.
REQ-018 MUL: each CALC cycle SHALL perform BITS_PER_CYCLE bits; CALC lasts DATA_WIDTH/BITS_PER_CYCLE cycles; z starts at 0.
REQ-019 ADD: one CALC cycle, p = x+y, minus q if the sum >= q (DATA_WIDTH+1-bit sum).
REQ-020 SUB: one CALC cycle, p = x-y, plus q if x < y.
REQ-021 On the last CALC cycle, p_o and err_o SHALL load and the FSM SHALL move to DONE.
REQ-022 DONE: out_valid=1; p_o and err_o SHALL stay stable until out_ready is high, then the FSM SHALL return to IDLE.
REQ-023 Latency from the acceptance edge to out_valid high: MUL = DATA_WIDTH/BITS_PER_CYCLE+1 cycles; ADD/SUB = 2 cycles; error = 1 cycle.
REQ-024 Back-to-back: in_ready SHALL rise in the cycle after the DONE handshake, giving no acceptance in the same cycle as the result handshake.
REQ-025 abort_i high in CALC or DONE SHALL return the FSM to IDLE on the next edge, with out_valid low and p_o unchanged.
REQ-026 abort_i SHALL have priority over out_ready; abort_i in IDLE SHALL have no effect.
REQ-027 The round counter SHALL be $clog2(DATA_WIDTH/BITS_PER_CYCLE)+1 bits wide and SHALL clear on every entry to CALC.

Reset
REQ-028 During reset: state=IDLE, round counter=0, internal z/x/y/q registers=0, p_o=0, err_o=0, out_valid=0, in_ready=1 after reset release.
REQ-029 Reset asserted mid-operation SHALL discard the operation; no out_valid pulse SHALL follow.

Structure
REQ-030 Package sv_modmul_pkg SHALL hold the mode enum (MODE_MUL, MODE_ADD, MODE_SUB) and the FSM state typedef.
REQ-031 One combinational sub-module, sv_modmul_step, SHALL implement BITS_PER_CYCLE reduction rounds (inputs q, y, z, x bit slice; output z_next), instantiated once.
REQ-032 No multiplier primitives SHALL be used; only adders, subtractors, comparators and muxes.

Verification (bench parameters DATA_WIDTH=8, BITS_PER_CYCLE=2, q=251)
REQ-033 MUL x=200, y=100 -> p_o=171, err_o=0, out_valid rises exactly 5 cycles after acceptance.
REQ-034 ADD x=200, y=100 -> p_o=49 after 2 cycles; SUB x=100, y=200 -> p_o=151 after 2 cycles.
REQ-035 x=251 with any mode -> err_o=1, p_o=0, out_valid 1 cycle after acceptance.
REQ-036 out_ready held low for 10 cycles in DONE -> p_o=171 stable and out_valid high throughout; in_ready low until the cycle after the handshake.
REQ-037 abort_i at CALC cycle 2, then a new MUL with x=3, y=5 -> no out_valid for the aborted operation; p_o=15.
REQ-038 areset pulsed during CALC -> all outputs at reset values, in_ready=1 after release, no out_valid.
